viterbi_pmu_ctrl: RTL and testbench

Frame sequencer for the 4-state Viterbi path metric unit (pmu).
- Accepts branch-metric symbols under a valid/ready handshake.
- Drives the PMU's sel0/sel1 selects and the path-metric clear and update enable for each trellis stage.
- Hands the frame to traceback for a fixed number of cycles, then pulses done.

---
 rtl/viterbi_pmu_ctrl.sv | 138 +++++++++++++
 tb/tb_viterbi_pmu_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_pmu_ctrl.sv
// Frame sequencer for the 4-state Viterbi path metric unit: symbol handshake,
// PMU select/clear/update control, traceback window and done pulse.
module viterbi_pmu_ctrl #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned TB_DEPTH  = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             acs_en,
    output logic             pm_clr,
    output logic             sel0,
    output logic [1:0]       sel1,
    output logic             tb_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sym_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_TAIL = CNT_W'(FRAME_LEN - 2);
    localparam logic [CNT_W-1:0] TB_LOAD  = CNT_W'(TB_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FIRST = 3'd2,
        ACS   = 3'd3,
        TB    = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt_d, tbc, tbc_d;
    logic             ready_d, clr_d, sel0_d, tb_en_d, busy_d, done_d;
    logic [1:0]       sel1_d;

    // A symbol is consumed whenever the registered ready meets a valid.
    assign acs_en = sym_valid & sym_ready;

    // Next state and counters; abort overrides any handshake outside IDLE.
    always_comb begin
        state_d = state;
        cnt_d   = sym_cnt;
        tbc_d   = tbc;
        case (state)
            IDLE:  if (start) state_d = CLEAR;
            CLEAR: begin
                state_d = FIRST;
                cnt_d   = '0;
            end
            FIRST: if (acs_en) begin
                state_d = ACS;
                cnt_d   = CNT_W'(1);
            end
            ACS: if (acs_en) begin
                if (sym_cnt == CNT_LAST) begin
                    state_d = TB;
                    cnt_d   = CNT_FULL;
                    tbc_d   = TB_LOAD;
                end else begin
                    cnt_d = sym_cnt + CNT_W'(1);
                end
            end
            TB: begin
                if (tbc == '0) state_d = DONE;
                else           tbc_d   = tbc - CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ready_d = 1'b0;
        clr_d   = 1'b0;
        sel0_d  = 1'b0;
        sel1_d  = 2'b00;
        tb_en_d = 1'b0;
        busy_d  = (state_d != IDLE);
        done_d  = 1'b0;
        case (state_d)
            CLEAR: clr_d   = 1'b1;
            FIRST: ready_d = 1'b1;
            ACS: begin
                ready_d = 1'b1;
                sel0_d  = 1'b1;
                if (cnt_d == CNT_W'(1))  sel1_d = 2'b01;
                else if (cnt_d >= CNT_TAIL) sel1_d = 2'b11;
                else                        sel1_d = 2'b10;
            end
            TB: begin
                tb_en_d = 1'b1;
                sel0_d  = 1'b1;
                sel1_d  = 2'b11;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sym_cnt   <= '0;
            tbc       <= '0;
            sym_ready <= 1'b0;
            pm_clr    <= 1'b0;
            sel0      <= 1'b0;
            sel1      <= 2'b00;
            tb_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            sym_cnt   <= cnt_d;
            tbc       <= tbc_d;
            sym_ready <= ready_d;
            pm_clr    <= clr_d;
            sel0      <= sel0_d;
            sel1      <= sel1_d;
            tb_en     <= tb_en_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_viterbi_pmu_ctrl.sv
// Bench for viterbi_pmu_ctrl: per-cycle comparison against a frame-level
// model (clear phase, accepted count, traceback cycles left).
module tb_viterbi_pmu_ctrl;

    localparam int unsigned FL  = 8;
    localparam int unsigned TBD = 4;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, sym_valid;
    logic          sym_ready, acs_en, pm_clr, sel0, tb_en, busy, done;
    logic [1:0]    sel1;
    logic [CW-1:0] sym_cnt;

    viterbi_pmu_ctrl #(.FRAME_LEN(FL), .TB_DEPTH(TBD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .acs_en(acs_en), .pm_clr(pm_clr), .sel0(sel0),
        .sel1(sel1), .tb_en(tb_en), .busy(busy), .done(done), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Frame-level reference model
    logic m_active = 1'b0;
    logic m_clear  = 1'b0;
    int   m_n      = 0;
    int   m_tb     = 0;

    logic [12:0] got_v, exp_v;
    logic        o_acs, o_sel0, o_clr, o_tb, o_done, o_busy;
    logic [1:0]  o_sel1;
    logic [CW-1:0] o_cnt;

    // One clock cycle: drive inputs, capture DUT and model outputs, advance model.
    task automatic step(input logic s, input logic a, input logic v);
        logic e_ready, e_tb, e_done, e_sel0, mask_cnt;
        logic [1:0] e_sel1;
        @(negedge clk);
        start = s; abort = a; sym_valid = v;
        #1;
        e_ready  = m_active && !m_clear && (m_n < FL);
        e_tb     = m_active && !m_clear && (m_n == FL) && (m_tb > 0);
        e_done   = m_active && !m_clear && (m_n == FL) && (m_tb == 0);
        e_sel0   = e_ready ? (m_n > 0) : e_tb;
        if (e_tb)            e_sel1 = 2'd3;
        else if (!e_ready)   e_sel1 = 2'd0;
        else if (m_n == 0)   e_sel1 = 2'd0;
        else if (m_n == 1)   e_sel1 = 2'd1;
        else if (m_n >= FL - 2) e_sel1 = 2'd3;
        else                 e_sel1 = 2'd2;
        mask_cnt = m_active && m_clear;
        exp_v = {e_ready, e_ready & v, mask_cnt, e_done ? 1'b0 : e_sel0,
                 e_done ? 2'b00 : e_sel1, e_tb, m_active, e_done,
                 mask_cnt ? CW'(0) : CW'(m_n)};
        got_v = {sym_ready, acs_en, pm_clr, e_done ? 1'b0 : sel0,
                 e_done ? 2'b00 : sel1, tb_en, busy, done,
                 mask_cnt ? CW'(0) : sym_cnt};
        o_acs = acs_en; o_sel0 = sel0; o_sel1 = sel1; o_clr = pm_clr;
        o_tb = tb_en; o_done = done; o_busy = busy; o_cnt = sym_cnt;
        @(posedge clk);
        if (!m_active) begin
            if (s) begin m_active = 1'b1; m_clear = 1'b1; end
        end else if (a) begin
            m_active = 1'b0; m_clear = 1'b0; m_n = 0;
        end else if (m_clear) begin
            m_clear = 1'b0; m_n = 0;
        end else if (e_ready) begin
            if (v) begin
                m_n++;
                if (m_n == FL) m_tb = TBD;
            end
        end else if (e_tb) begin
            m_tb--;
        end else begin
            m_active = 1'b0;
        end
    endtask

    task automatic run_to_idle(input string tag);
        int n = 0;
        while (m_active && n < 60) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL %s_drain: got %b want %b", tag, got_v, exp_v);
            end
            n++;
        end
        checks++;
        if (m_active) begin
            failures++;
            $display("FAIL %s_drain_timeout: frame still active after %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sym_ready, acs_en, pm_clr, sel0, sel1, tb_en, busy, done, sym_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0",
                     {sym_ready, acs_en, pm_clr, sel0, sel1, tb_en, busy, done, sym_cnt});
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (got_v !== exp_v || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: got %b want %b", got_v, exp_v);
            end
        end
    endtask

    task automatic test_full_frame();
        int exp_s1 [8] = '{0, 1, 2, 2, 2, 2, 3, 3};
        int exp_s0 [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
        int k = 1, n_acs = 0, n_clr = 0, n_tb = 0, done_k = -1;
        step(1'b1, 1'b0, 1'b1);
        while (done_k < 0 && k < 40) begin
            step(1'b0, 1'b0, 1'b1);
            k++;
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL full_cycle%0d: got %b want %b", k, got_v, exp_v);
            end
            if (o_clr) n_clr++;
            if (o_tb) n_tb++;
            if (o_done) done_k = k;
            if (o_acs) begin
                if (n_acs < 8) begin
                    checks++;
                    if (o_sel1 !== 2'(exp_s1[n_acs]) || o_sel0 !== 1'(exp_s0[n_acs])) begin
                        failures++;
                        $display("FAIL full_sel_sym%0d: got sel0=%b sel1=%b want sel0=%0d sel1=%0d",
                                 n_acs, o_sel0, o_sel1, exp_s0[n_acs], exp_s1[n_acs]);
                    end
                end
                n_acs++;
            end
        end
        checks++;
        if (n_clr != 1 || n_acs != 8 || n_tb != 4) begin
            failures++;
            $display("FAIL full_counts: got clr=%0d acs=%0d tb=%0d want 1 8 4", n_clr, n_acs, n_tb);
        end
        checks++;
        if (done_k != 15) begin
            failures++;
            $display("FAIL full_latency: got %0d want 15", done_k);
        end
        run_to_idle("full");
    endtask

    task automatic test_stall();
        int k = 1, done_k = -1, acc = 0, stall = 0;
        logic v;
        step(1'b1, 1'b0, 1'b1);
        while (done_k < 0 && k < 40) begin
            v = !(acc == 3 && stall < 3);
            if (!v) stall++;
            step(1'b0, 1'b0, v);
            k++;
            if (o_acs) acc++;
            if (o_done) done_k = k;
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL stall_cycle%0d: got %b want %b", k, got_v, exp_v);
            end
            if (!v) begin
                checks++;
                if (o_cnt !== CW'(3) || o_sel1 !== 2'b10 || o_acs !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold: got cnt=%0d sel1=%b acs=%b want 3 10 0",
                             o_cnt, o_sel1, o_acs);
                end
            end
        end
        checks++;
        if (done_k != 18) begin
            failures++;
            $display("FAIL stall_latency: got %0d want 18", done_k);
        end
        run_to_idle("stall");
    endtask

    task automatic test_abort();
        int n = 0, dones = 0;
        step(1'b1, 1'b0, 1'b1);
        while (!(m_active && !m_clear && m_n == 5) && n < 20) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (o_acs !== 1'b1 || o_cnt !== CW'(5)) begin
            failures++;
            $display("FAIL abort_handshake: got acs=%b cnt=%0d want 1 5", o_acs, o_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (o_done) dones++;
            checks++;
            if (got_v !== exp_v || o_busy !== 1'b0 || o_cnt !== CW'(0)) begin
                failures++;
                $display("FAIL abort_idle: got %b want %b", got_v, exp_v);
            end
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (o_clr !== 1'b1 || got_v !== exp_v) begin
            failures++;
            $display("FAIL abort_restart_clr: got pm_clr=%b vec %b want 1 vec %b", o_clr, got_v, exp_v);
        end
        run_to_idle("abort");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic seen_done = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        while (!seen_done && n < 40) begin
            step(!m_clear && m_n == FL, 1'b0, 1'b1);
            seen_done = o_done;
            n++;
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL b2b_frame: got %b want %b", got_v, exp_v);
            end
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (o_busy !== 1'b0 || got_v !== exp_v) begin
            failures++;
            $display("FAIL b2b_idle: got busy=%b vec %b want 0 vec %b", o_busy, got_v, exp_v);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (o_clr !== 1'b1 || got_v !== exp_v) begin
            failures++;
            $display("FAIL b2b_clear: got pm_clr=%b vec %b want 1 vec %b", o_clr, got_v, exp_v);
        end
        run_to_idle("b2b");
    endtask

    task automatic test_random();
        logic s, a, v;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            step(s, a, v);
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL random_cycle%0d: got %b want %b", i, got_v, exp_v);
            end
        end
        run_to_idle("random");
    endtask

    task automatic test_async_reset();
        int n = 0;
        step(1'b1, 1'b0, 1'b1);
        while (!(m_active && !m_clear && m_n == FL && m_tb == 2) && n < 30) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        @(negedge clk);
        sym_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({sym_ready, acs_en, pm_clr, sel0, sel1, tb_en, busy, done, sym_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset_outputs: got %b want 0",
                     {sym_ready, acs_en, pm_clr, sel0, sel1, tb_en, busy, done, sym_cnt});
        end
        m_active = 1'b0; m_clear = 1'b0; m_n = 0; m_tb = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (got_v !== exp_v || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_idle: got %b want %b", got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_abort();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
